// File: rtl/cdb_broadcast.sv
// Common-data-bus arbiter: buffers each functional unit's results in a private
// 2-entry FIFO and broadcasts one result per cycle, chosen round-robin.
module cdb_broadcast #(
  parameter int NUM_FU = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  localparam int SRC_W = $clog2(NUM_FU)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*DATA_W-1:0] fu_data,
  output logic [NUM_FU-1:0]        fu_ready,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [SRC_W-1:0]         cdb_src,
  output logic                     busy,
  output logic                     err_tag0
);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } result_t;

  result_t           mem   [NUM_FU][2];
  logic [1:0]        count [NUM_FU];
  logic [NUM_FU-1:0] wr_ptr, rd_ptr;
  logic [NUM_FU-1:0] full, empty, accept, push, pop;
  logic [SRC_W-1:0]  ptr, gnt_idx, scan_idx, next_ptr;
  logic              gnt_valid;
  result_t           gnt_head;

  // Per-unit status; ready is derived from registered occupancy only, so a
  // full FIFO refuses input even in the cycle it is being popped.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    full   = '0;
    empty  = '0;
    accept = '0;
    push   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      full[i]   = (count[i] == 2'd2);
      empty[i]  = (count[i] == 2'd0);
      accept[i] = fu_valid[i] && !full[i] && !flush;
      push[i]   = accept[i] && (fu_tag[i*TAG_W +: TAG_W] != '0);
    end
  end

  assign fu_ready = ~full & {NUM_FU{~flush}};

  // Round-robin scan starting at ptr; the first non-empty FIFO wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan_idx = SRC_W'((int'(ptr) + k) % NUM_FU);
      if (!gnt_valid && !empty[scan_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (gnt_valid) pop[gnt_idx] = 1'b1;
  end

  assign gnt_head = mem[gnt_idx][rd_ptr[gnt_idx]];
  assign next_ptr = (gnt_idx == SRC_W'(NUM_FU - 1)) ? '0 : gnt_idx + 1'b1;

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is always written with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < NUM_FU; i++) count[i] <= 2'd0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < NUM_FU; i++) count[i] <= 2'd0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wr_ptr[i] <= ~wr_ptr[i];
        if (pop[i])  rd_ptr[i] <= ~rd_ptr[i];
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 2'd1;
          2'b01:   count[i] <= count[i] - 2'd1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // NOTE: the storage array has no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= '{tag:  fu_tag[i*TAG_W +: TAG_W],
                               data: fu_data[i*DATA_W +: DATA_W]};
      end
    end
  end

  // Broadcast register and round-robin pointer; tag/data/src hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (flush) begin
      ptr       <= '0;
      cdb_valid <= 1'b0;
    end else begin
      cdb_valid <= gnt_valid;
      if (gnt_valid) begin
        ptr      <= next_ptr;
        cdb_tag  <= gnt_head.tag;
        cdb_data <= gnt_head.data;
        cdb_src  <= gnt_idx;
      end
    end
  end

  // Tag 0 means "operand ready" system-wide; accepting one is a producer bug.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_tag0 <= 1'b0;
    end else if (|(accept & ~push)) begin
      err_tag0 <= 1'b1;
    end
  end

  assign busy = !(&empty) || cdb_valid;

endmodule
